// File: rtl/fifo_byte_ctrl.sv
// Pointer and flag controller for a word-in / byte-out FIFO.
// Words of 2*DATA_WIDTH bits are pushed whole; bytes are popped upper half
// first, then lower half. A word slot is released only after its second byte.
module fifo_byte_ctrl #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  same_read,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH+1:0] byte_count
);

    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(2 ** ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic                  half;
    logic [ADDR_WIDTH:0]   word_count;
    logic                  rd_ok;
    logic                  rd_done;

    // Accept logic and status flags, all combinational from state and requests
    always_comb begin
        empty      = (word_count == '0);
        full       = (word_count == DEPTH);
        rd_ok      = rd & ~empty;
        rd_done    = rd_ok & half;
        // A write into a full FIFO is allowed when the same edge frees the
        // slot being read; in that case w_addr == r_addr and the consumer has
        // already taken the old lower byte combinationally.
        w_en       = wr & (~full | rd_done);
        w_addr     = wptr;
        r_addr     = rptr;
        same_read  = half;
        byte_count = {word_count, 1'b0} - {{(ADDR_WIDTH+1){1'b0}}, half};
    end

    // Pointer, half-select and occupancy registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            half       <= 1'b0;
            word_count <= '0;
        end else begin
            if (w_en) begin
                wptr <= wptr + ADDR_WIDTH'(1);
            end
            if (rd_ok) begin
                half <= ~half;
                if (half) begin
                    rptr <= rptr + ADDR_WIDTH'(1);
                end
            end
            if (w_en && !rd_done) begin
                word_count <= word_count + (ADDR_WIDTH+1)'(1);
            end else if (!w_en && rd_done) begin
                word_count <= word_count - (ADDR_WIDTH+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_byte_ctrl.sv
// Directed testbench for fifo_byte_ctrl with a behavioural register file
// attached so that the byte order seen by the consumer can be checked.
module tb_fifo_byte_ctrl;

    localparam int AW = 4;

    logic          clk;
    logic          reset;
    logic          wr;
    logic          rd;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] r_addr;
    logic          same_read;
    logic          empty;
    logic          full;
    logic [AW+1:0] byte_count;

    logic [15:0]   wdata;
    logic [15:0]   mem [16];
    logic [7:0]    rbyte;

    int checks;
    int errors;

    fifo_byte_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr),
        .rd         (rd),
        .w_en       (w_en),
        .w_addr     (w_addr),
        .r_addr     (r_addr),
        .same_read  (same_read),
        .empty      (empty),
        .full       (full),
        .byte_count (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: synchronous write, asynchronous half read
    always @(posedge clk) begin
        if (w_en) mem[w_addr] <= wdata;
    end
    assign rbyte = same_read ? mem[r_addr][7:0] : mem[r_addr][15:8];

    task automatic drive(input logic w, input logic r, input logic [15:0] d);
        @(negedge clk);
        wr    = w;
        rd    = r;
        wdata = d;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        wr = 1'b0; rd = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; wr = 1'b1; rd = 1'b0;
        #1;
        checks++;
        if ({empty, full, byte_count, w_addr, r_addr, same_read} !== {1'b1, 1'b0, 6'd0, 4'd0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got e=%b f=%b bc=%0d wa=%0d ra=%0d sr=%b, need e=1 f=0 bc=0 wa=0 ra=0 sr=0",
                     empty, full, byte_count, w_addr, r_addr, same_read);
        end
        checks++;
        if (w_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_w_en: got %b need 1", w_en);
        end
        step();
        checks++;
        if (byte_count !== 6'd0 || w_addr !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold: got bc=%0d wa=%0d need 0 0", byte_count, w_addr);
        end
        @(negedge clk);
        wr = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_empty_read();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 16'h0000);
            checks++;
            if (w_en !== 1'b0) begin
                errors++;
                $display("FAIL empty_rd_w_en cycle %0d: got %b need 0", i, w_en);
            end
            step();
            checks++;
            if ({empty, byte_count, r_addr, same_read} !== {1'b1, 6'd0, 4'd0, 1'b0}) begin
                errors++;
                $display("FAIL empty_rd cycle %0d: got e=%b bc=%0d ra=%0d sr=%b need 1 0 0 0",
                         i, empty, byte_count, r_addr, same_read);
            end
        end
    endtask

    task automatic test_single_word();
        drive(1'b1, 1'b0, 16'hA1B2);
        step();
        checks++;
        if (empty !== 1'b0 || byte_count !== 6'd2) begin
            errors++;
            $display("FAIL single_after_wr: got e=%b bc=%0d need 0 2", empty, byte_count);
        end
        drive(1'b0, 1'b1, 16'h0000);
        checks++;
        if (same_read !== 1'b0 || rbyte !== 8'hA1) begin
            errors++;
            $display("FAIL single_byte0: got sr=%b byte=%h need 0 a1", same_read, rbyte);
        end
        step();
        checks++;
        if (byte_count !== 6'd1) begin
            errors++;
            $display("FAIL single_bc1: got %0d need 1", byte_count);
        end
        drive(1'b0, 1'b1, 16'h0000);
        checks++;
        if (same_read !== 1'b1 || rbyte !== 8'hB2) begin
            errors++;
            $display("FAIL single_byte1: got sr=%b byte=%h need 1 b2", same_read, rbyte);
        end
        step();
        checks++;
        if ({empty, r_addr, byte_count} !== {1'b1, 4'd1, 6'd0}) begin
            errors++;
            $display("FAIL single_done: got e=%b ra=%0d bc=%0d need 1 1 0", empty, r_addr, byte_count);
        end
        drive(1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, {8'(8'h40 + i), 8'(8'h80 + i)});
            step();
        end
        checks++;
        if ({full, empty, byte_count, w_addr} !== {1'b1, 1'b0, 6'd32, 4'd0}) begin
            errors++;
            $display("FAIL fill_full: got f=%b e=%b bc=%0d wa=%0d need 1 0 32 0", full, empty, byte_count, w_addr);
        end
        drive(1'b1, 1'b0, 16'hDEAD);
        checks++;
        if (w_en !== 1'b0) begin
            errors++;
            $display("FAIL fill_drop_w_en: got %b need 0", w_en);
        end
        step();
        checks++;
        if ({full, byte_count, w_addr, r_addr} !== {1'b1, 6'd32, 4'd0, 4'd0}) begin
            errors++;
            $display("FAIL fill_drop_state: got f=%b bc=%0d wa=%0d ra=%0d need 1 32 0 0", full, byte_count, w_addr, r_addr);
        end
    endtask

    task automatic test_full_rw();
        drive(1'b0, 1'b1, 16'h0000);
        checks++;
        if (rbyte !== 8'h40) begin
            errors++;
            $display("FAIL fullrw_byte0: got %h need 40", rbyte);
        end
        step();
        checks++;
        if ({full, byte_count, same_read} !== {1'b1, 6'd31, 1'b1}) begin
            errors++;
            $display("FAIL fullrw_half: got f=%b bc=%0d sr=%b need 1 31 1", full, byte_count, same_read);
        end
        drive(1'b1, 1'b1, 16'hCAFE);
        checks++;
        if ({w_en, w_addr, r_addr, rbyte} !== {1'b1, 4'd0, 4'd0, 8'h80}) begin
            errors++;
            $display("FAIL fullrw_same: got we=%b wa=%0d ra=%0d byte=%h need 1 0 0 80", w_en, w_addr, r_addr, rbyte);
        end
        step();
        checks++;
        if ({full, r_addr, w_addr, byte_count, same_read} !== {1'b1, 4'd1, 4'd1, 6'd32, 1'b0}) begin
            errors++;
            $display("FAIL fullrw_after: got f=%b ra=%0d wa=%0d bc=%0d sr=%b need 1 1 1 32 0",
                     full, r_addr, w_addr, byte_count, same_read);
        end
        checks++;
        if (mem[0] !== 16'hCAFE) begin
            errors++;
            $display("FAIL fullrw_overwrite: got %h need cafe", mem[0]);
        end
        drive(1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_empty_wr_rd();
        do_reset();
        drive(1'b1, 1'b1, 16'h1234);
        checks++;
        if (w_en !== 1'b1) begin
            errors++;
            $display("FAIL empty_wrrd_w_en: got %b need 1", w_en);
        end
        step();
        checks++;
        if ({byte_count, same_read, empty, r_addr} !== {6'd2, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL empty_wrrd_after: got bc=%0d sr=%b e=%b ra=%0d need 2 0 0 0", byte_count, same_read, empty, r_addr);
        end
        drive(1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_stream();
        int nbytes;
        do_reset();
        nbytes = 0;
        // cycle 0 writes only; cycles 1..19 write and read; cycles 20..40 read only
        for (int c = 0; c <= 40; c++) begin
            drive(c < 20, c >= 1, {8'(2 * c + 1), 8'(2 * c + 2)});
            if (c >= 1) begin
                checks++;
                if (empty !== 1'b0 || rbyte !== 8'(c)) begin
                    errors++;
                    $display("FAIL stream_byte %0d: got e=%b byte=%h need 0 %h", c, empty, rbyte, 8'(c));
                end
                nbytes++;
            end
            step();
            if (c == 0) begin
                checks++;
                if (byte_count !== 6'd2) begin
                    errors++;
                    $display("FAIL stream_first_bc: got %0d need 2", byte_count);
                end
            end
            if (c == 19) begin
                checks++;
                if (byte_count !== 6'd21 || w_addr !== 4'd4) begin
                    errors++;
                    $display("FAIL stream_mid: got bc=%0d wa=%0d need 21 4", byte_count, w_addr);
                end
            end
        end
        checks++;
        if ({empty, byte_count, r_addr, nbytes} !== {1'b1, 6'd0, 4'd4, 32'd40}) begin
            errors++;
            $display("FAIL stream_end: got e=%b bc=%0d ra=%0d n=%0d need 1 0 4 40", empty, byte_count, r_addr, nbytes);
        end
        // restart and abort mid-stream with an asynchronous reset
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b1, 16'h5500 + 16'(c));
            step();
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({empty, full, byte_count, w_addr, r_addr, same_read} !== {1'b1, 1'b0, 6'd0, 4'd0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL stream_reset: got e=%b f=%b bc=%0d wa=%0d ra=%0d sr=%b need 1 0 0 0 0 0",
                     empty, full, byte_count, w_addr, r_addr, same_read);
        end
        wr = 1'b0; rd = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        wr     = 1'b0;
        rd     = 1'b0;
        wdata  = 16'h0000;
        test_reset();
        test_empty_read();
        test_single_word();
        test_fill();
        test_full_rw();
        test_empty_wr_rd();
        test_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
